// File: rtl/ps2_key_serializer_if.sv
// ps2_key_serializer_if
// Key-event input and PS/2 line outputs of ps2_key_serializer, bundled as one port.
//   ps2_key  [10] toggles once per event, [9] pressed, [8] extended, [7:0] scan code
//   ps2_clk  emulated PS/2 clock, idle high
//   ps2_data emulated PS/2 data, idle high
//   busy     a sequence is in flight or events are waiting
//   overflow one-cycle pulse per dropped event
// master: the event source (hps_io side). slave: the serializer.
interface ps2_key_serializer_if;
  logic [10:0] ps2_key;
  logic        ps2_clk;
  logic        ps2_data;
  logic        busy;
  logic        overflow;

  modport master (
    output ps2_key,
    input  ps2_clk, ps2_data, busy, overflow
  );

  modport slave (
    input  ps2_key,
    output ps2_clk, ps2_data, busy, overflow
  );
endinterface

// File: rtl/ps2_key_serializer.sv
// ps2_key_serializer
// Converts hps_io key events into PS/2 device-to-host frames on a ps2_clk /
// ps2_data pair. Each event expands to E0 (extended), F0 (release), then the
// scan code; every byte is sent as an 11-bit frame {stop, odd parity, d7..d0,
// start}, LSB first, followed by GAP idle cycles with both lines high.
//
// Build option: define PS2_EVQ_EN to buffer events in a 2**FIFO_AW deep queue.
// Without it, a single holding register accepts an event only while empty.
//
// Ports:
//   clk50    system clock (only clock)
//   reset_n  asynchronous active-low reset; lines go high at once, queue flushed
//   bus      ps2_key_serializer_if.slave (ps2_key in; ps2_clk, ps2_data, busy,
//            overflow out)
module ps2_key_serializer #(
  parameter int HALF    = 2000,  // clk50 cycles per PS/2 clock half-period
  parameter int GAP     = 4000,  // idle cycles between bytes
  parameter int FIFO_AW = 3      // log2 of event-queue depth
) (
  input  logic                clk50,
  input  logic                reset_n,
  ps2_key_serializer_if.slave bus
);

  localparam int CNT_MAX = (HALF > GAP) ? HALF : GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  // The LOAD cycle that follows GAP still has both lines high, so GAP itself
  // ends one cycle early to keep the idle stretch exactly GAP cycles long.
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP >= 2) ? GAP - 2 : 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_BIT,
    ST_GAP
  } state_t;

  // Event detect
  logic       r_armed;
  logic       r_shadow;
  logic       r_evt_vld;
  logic [9:0] r_evt;

  // Queue
  logic [FIFO_AW:0] r_count;
  logic             r_overflow;
  logic             w_push;
  logic             w_pop;
  logic             w_q_vld;
  logic [9:0]       w_q_data;

  // Sequencer
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_bit;
  logic [9:0]       r_frame;   // frame bits still to send, bit 0 next
  logic             r_need_e0;
  logic             r_need_f0;
  logic             r_last;
  logic [7:0]       r_code;
  logic             r_ps2_clk;
  logic             r_ps2_data;
  logic [7:0]       w_byte;
  logic [10:0]      w_frame;

  // ---------------------------------------------------------------------------
  // Event detect. The first cycle after reset only loads the shadow, so the
  // level of ps2_key[10] at reset release never counts as a toggle.
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      r_armed   <= 1'b0;
      r_shadow  <= 1'b0;
      r_evt_vld <= 1'b0;
      r_evt     <= '0;
    end else begin
      r_armed   <= 1'b1;
      r_shadow  <= bus.ps2_key[10];
      r_evt_vld <= r_armed && (bus.ps2_key[10] != r_shadow);
      r_evt     <= bus.ps2_key[9:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Queue: occupancy count and drop pulse are shared; storage depends on build.
  // ---------------------------------------------------------------------------
  assign w_pop   = (r_state == ST_IDLE) && w_q_vld;
  assign w_q_vld = (r_count != '0);

`ifdef PS2_EVQ_EN
  localparam logic [FIFO_AW:0] DEPTH = {1'b1, {FIFO_AW{1'b0}}};

  logic [9:0]         r_mem [0:(1 << FIFO_AW) - 1];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;

  // A full queue still takes a write when IDLE pops in the same cycle.
  assign w_push   = r_evt_vld && ((r_count != DEPTH) || w_pop);
  assign w_q_data = r_mem[r_rd_ptr];

  // NOTE: the storage array has no reset; the count and pointers alone decide
  // which entries are valid, so flushing them empties the queue.
  always_ff @(posedge clk50) begin
    if (w_push) r_mem[r_wr_ptr] <= r_evt;
  end

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end
`else
  logic [9:0] r_hold;

  // Accept only into an empty register; a pop in the same cycle does not help.
  assign w_push   = r_evt_vld && (r_count == '0);
  assign w_q_data = r_hold;

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) r_hold <= '0;
    else if (w_push) r_hold <= r_evt;
  end
`endif

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= r_evt_vld && !w_push;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Byte selection: pending prefixes go first, the scan code last.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: assign a default before any branch so no path holds the old value,
    // which would infer a latch.
    w_byte = r_code;
    if (r_need_e0)      w_byte = 8'hE0;
    else if (r_need_f0) w_byte = 8'hF0;
  end

  assign w_frame = {1'b1, ~^w_byte, w_byte, 1'b0};

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_frame    <= '1;
      r_need_e0  <= 1'b0;
      r_need_f0  <= 1'b0;
      r_last     <= 1'b0;
      r_code     <= '0;
      r_ps2_clk  <= 1'b1;
      r_ps2_data <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_q_vld) begin
            r_need_e0 <= w_q_data[8];
            r_need_f0 <= ~w_q_data[9];
            r_code    <= w_q_data[7:0];
            r_state   <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          r_ps2_data <= w_frame[0];           // start bit, clock stays high
          r_ps2_clk  <= 1'b1;
          r_frame    <= w_frame[10:1];
          r_bit      <= '0;
          r_cnt      <= '0;
          r_last     <= !(r_need_e0 || r_need_f0);
          if (r_need_e0) r_need_e0 <= 1'b0;
          else           r_need_f0 <= 1'b0;
          r_state    <= ST_BIT;
        end

        ST_BIT: begin
          if (r_cnt != HALF_LAST) begin
            r_cnt <= r_cnt + 1'b1;
          end else begin
            r_cnt <= '0;
            if (r_ps2_clk) begin
              r_ps2_clk <= 1'b0;              // data already stable
            end else begin
              // Rising clock edge: next bit goes out with the high phase.
              r_ps2_clk <= 1'b1;
              if (r_bit == 4'd10) begin
                r_ps2_data <= 1'b1;
                r_state    <= ST_GAP;
              end else begin
                r_bit      <= r_bit + 1'b1;
                r_ps2_data <= r_frame[0];
                r_frame    <= {1'b1, r_frame[9:1]};
              end
            end
          end
        end

        ST_GAP: begin
          if (r_cnt != GAP_LAST) begin
            r_cnt <= r_cnt + 1'b1;
          end else begin
            r_cnt   <= '0;
            r_state <= r_last ? ST_IDLE : ST_LOAD;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ps2_clk  = r_ps2_clk;
  assign bus.ps2_data = r_ps2_data;
  assign bus.busy     = (r_state != ST_IDLE) || w_q_vld;
  assign bus.overflow = r_overflow;

endmodule

// File: tb/tb_ps2_key_serializer.sv
// tb_ps2_key_serializer
// Drives randomized key events into ps2_key_serializer (HALF=4, GAP=8) and
// decodes the ps2_clk/ps2_data lines back into frames, comparing them with the
// frames predicted from each event's pressed/extended/code fields. Also checks
// reset values, start-bit/clock timing, byte spacing, overflow accounting for
// the build selected by PS2_EVQ_EN, reset mid-frame and reset release with
// ps2_key[10] high.
module tb_ps2_key_serializer;

  localparam int HALF     = 4;
  localparam int GAP      = 8;
  localparam int FIFO_AW  = 3;
  localparam int DEPTH    = 1 << FIFO_AW;
  localparam int SPACING  = 22 * HALF + GAP;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  ps2_key_serializer_if u_if ();

  ps2_key_serializer #(
    .HALF    (HALF),
    .GAP     (GAP),
    .FIFO_AW (FIFO_AW)
  ) u_dut (
    .clk50   (clk),
    .reset_n (rst_n),
    .bus     (u_if)
  );

  initial forever #5 clk = ~clk;

  // Scoreboard counters
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Reference model: expected frames, in send order.
  logic [10:0] exp_q[$];

  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic par;
    par = ($countones(b) % 2 == 0);   // odd parity over data + parity bit
    return {1'b1, par, b, 1'b0};
  endfunction

  function automatic void model_event(input logic [9:0] ev);
    if (ev[8])  exp_q.push_back(frame_of(8'hE0));
    if (!ev[9]) exp_q.push_back(frame_of(8'hF0));
    exp_q.push_back(frame_of(ev[7:0]));
  endfunction

  // Line monitor (samples on the falling system-clock edge)
  int          cyc = 0;
  int          mon_nbits = 0;
  logic [10:0] mon_bits = '0;
  logic [10:0] got_q[$];
  int          start_q[$];
  int          ovf_cnt = 0;
  int          first_busy = -1;
  int          first_data_fall = -1;
  int          first_clk_fall = -1;
  logic        prev_clk = 1'b1;
  logic        prev_data = 1'b1;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      mon_nbits = 0;
      prev_clk  = 1'b1;
      prev_data = 1'b1;
    end else begin
      if (u_if.busy && first_busy < 0) first_busy = cyc;
      if (prev_data && !u_if.ps2_data && u_if.ps2_clk && mon_nbits == 0) begin
        start_q.push_back(cyc);
        if (first_data_fall < 0) first_data_fall = cyc;
      end
      if (prev_clk && !u_if.ps2_clk) begin
        if (first_clk_fall < 0) first_clk_fall = cyc;
        mon_bits = {u_if.ps2_data, mon_bits[10:1]};
        mon_nbits++;
        if (mon_nbits == 11) begin
          got_q.push_back(mon_bits);
          mon_nbits = 0;
        end
      end
      if (u_if.overflow) ovf_cnt++;
      prev_clk  = u_if.ps2_clk;
      prev_data = u_if.ps2_data;
    end
  end

  // Helpers
  task automatic clear_marks();
    first_busy      = -1;
    first_data_fall = -1;
    first_clk_fall  = -1;
  endtask

  // Toggle ps2_key[10] with new content; k is the edge that samples it.
  task automatic send_event(input logic [9:0] ev, output int k);
    @(negedge clk);
    u_if.ps2_key = {~u_if.ps2_key[10], ev};
    k = cyc + 1;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    repeat (3) @(negedge clk);
    while (u_if.busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, 32'(u_if.busy), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic compare_frames(input string tag);
    check({tag, "_nframes"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_frame"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    got_q.delete();
    exp_q.delete();
    start_q.delete();
  endtask

  function automatic logic [9:0] rand_event();
    return 10'($urandom);
  endfunction

  // Tests
  task automatic test_basic_press();
    int k;
    clear_marks();
    model_event(10'h21C);                   // pressed, not extended, 0x1C
    send_event(10'h21C, k);
    wait_idle("press1c", 1000);
    check("t_busy_rise", 32'(first_busy), 32'(k + 1));
    check("t_start_bit", 32'(first_data_fall), 32'(k + 3));
    check("t_clk_fall", 32'(first_clk_fall), 32'(k + 3 + HALF));
    if (got_q.size() > 0) check("press1c_bits", 32'(got_q[0]), 32'h438);
    compare_frames("press1c");
  endtask

  task automatic test_ext_release();
    int k;
    model_event(10'h175);                   // released, extended, 0x75
    send_event(10'h175, k);
    wait_idle("rel_e075", 1000);
    check("rel_e075_starts", 32'(start_q.size()), 32'd3);
    if (start_q.size() >= 3) begin
      check("rel_e075_gap01", 32'(start_q[1] - start_q[0]), 32'(SPACING));
      check("rel_e075_gap12", 32'(start_q[2] - start_q[1]), 32'(SPACING));
    end
    compare_frames("rel_e075");
  endtask

  task automatic test_random();
    int k;
    logic [9:0] ev;
    logic [9:0] ev2;
    for (int i = 0; i < 6; i++) begin
      ev = rand_event();
      model_event(ev);
      send_event(ev, k);
      wait_idle("rand1", 1000);
      compare_frames("rand1");
    end
    // Pairs a few cycles apart: both fit in either queue build.
    for (int i = 0; i < 3; i++) begin
      ev  = rand_event();
      ev2 = rand_event();
      model_event(ev);
      model_event(ev2);
      send_event(ev, k);
      repeat (4) @(negedge clk);
      send_event(ev2, k);
      wait_idle("rand2", 2000);
      compare_frames("rand2");
    end
  endtask

  task automatic test_overflow();
    int         k;
    int         exp_drops;
    logic [9:0] evs[10];
    logic       acc;
    ovf_cnt   = 0;
    exp_drops = 0;
    for (int i = 0; i < 10; i++) begin
      evs[i] = rand_event();
      send_event(evs[i], k);
    end
    // The first event is popped right away; later ones find it still in
    // flight, so only the buffer capacity decides what survives.
    for (int i = 0; i < 10; i++) begin
`ifdef PS2_EVQ_EN
      acc = (i <= DEPTH);
`else
      acc = (i == 0) || (i == 2);
`endif
      if (acc) model_event(evs[i]);
      else     exp_drops++;
    end
    wait_idle("ovf", 8000);
    check("ovf_pulses", 32'(ovf_cnt), 32'(exp_drops));
    compare_frames("ovf");
  endtask

  task automatic test_reset_mid_frame();
    int k;
    int n;
    logic [9:0] ev;
    ev = rand_event();
    send_event(ev, k);
    n = 0;
    while (mon_nbits < 5 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_reached_bit5", 32'(mon_nbits), 32'd5);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_clk", 32'(u_if.ps2_clk), 32'd1);
    check("rst_mid_data", 32'(u_if.ps2_data), 32'd1);
    check("rst_mid_busy", 32'(u_if.busy), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    check("rst_mid_no_resume", 32'(got_q.size()), 32'd0);
    check("rst_mid_no_bits", 32'(mon_nbits), 32'd0);
    check("rst_mid_idle", 32'(u_if.busy), 32'd0);
    got_q.delete();
    start_q.delete();
    // A fresh toggle after the reset is served normally.
    ev = rand_event();
    model_event(ev);
    send_event(ev, k);
    wait_idle("rst_after", 1000);
    compare_frames("rst_after");
  endtask

  initial begin
    u_if.ps2_key = 11'h400;                 // key[10] high through reset release
    repeat (2) @(negedge clk);
    check("reset_ps2_clk", 32'(u_if.ps2_clk), 32'd1);
    check("reset_ps2_data", 32'(u_if.ps2_data), 32'd1);
    check("reset_busy", 32'(u_if.busy), 32'd0);
    check("reset_overflow", 32'(u_if.overflow), 32'd0);

    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    check("release_k10_no_frame", 32'(got_q.size()), 32'd0);
    check("release_k10_busy", 32'(u_if.busy), 32'd0);

    test_basic_press();
    test_ext_release();
    test_random();
    check("no_overflow_so_far", 32'(ovf_cnt), 32'd0);
    test_overflow();
    test_reset_mid_frame();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ps2_key_serializer.md
# ps2_key_serializer

Converts MiSTer `hps_io` key events (`ps2_key[10:0]`) into genuine PS/2 device-to-host serial frames on a `ps2_clk`/`ps2_data` pair. The core's keyboard controller consumes those lines unchanged. The block sits between `hps_io` and the `pc8001m` core's `ps2_clk`/`ps2_data` inputs in the `emu` top level.

It queues key events, expands each event into a 1–3 byte scan-code sequence (E0 / F0 prefixes), and paces the frames at PS/2 bit rates.

## Interface
Parameters:
- `HALF`, default 2000: `clk50` cycles per PS/2 clock half-period (12.5 kHz at 50 MHz).
- `GAP`, default 4000: idle `clk50` cycles between consecutive bytes, with both lines high.
- `FIFO_AW`, default 3: log2 of event-queue depth (8 events).

Ports:
- `clk50`, input, 1: system clock. The block has one clock.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `ps2_key`, input, 11: [10] toggles on each event, [9] pressed, [8] extended, [7:0] scan code.
- `ps2_clk`, output, 1: emulated PS/2 clock, idle high.
- `ps2_data`, output, 1: emulated PS/2 data, idle high.
- `busy`, output, 1: high while a sequence is being sent or the queue is non-empty.
- `overflow`, output, 1: one-cycle pulse when an event is dropped.

## Operation
- Reset values: `ps2_clk`=1, `ps2_data`=1, `busy`=0, `overflow`=0. Queue is empty; sequencer is in IDLE.
- Event detect:
  - The shadow of `ps2_key[10]` is loaded, not compared, on the first cycle after `reset_n` deasserts. The edge state of `ps2_key` at reset release therefore never creates an event.
  - After that first cycle, any cycle where `ps2_key[10]` differs from the shadow is one event. The entry {pressed, ext, code} (10 bits) is written to the queue on the next edge.
- Queue:
  - Depth is 2^FIFO_AW.
  - A write to a full queue is dropped and `overflow` pulses.
  - A simultaneous read and write on a full queue is accepted.
- Byte expansion per event, in order: E0 if ext; F0 if not pressed; then code.
- Sequencer states:
  - IDLE: waits for a non-empty queue, then pops an entry.
  - LOAD: selects the next byte and builds the 11-bit frame {stop=1, parity, d7..d0, start=0}, sent LSB first.
  - BIT: sends the frame bit by bit, described below.
  - GAP: holds both lines high for GAP cycles. It then returns to LOAD if more bytes remain for the current entry, otherwise to IDLE.
- Parity is odd: parity = ~^byte.
- Each bit in BIT:
  - `ps2_data` takes the bit value while `ps2_clk` is high, and `ps2_clk` stays high for HALF cycles.
  - `ps2_clk` is then driven low for HALF cycles, with `ps2_data` held stable.
  - After bit 10, the sequencer goes to GAP.
- Counters: the half-period counter is sized to hold max(HALF, GAP). The bit counter counts 0..10 and clears in LOAD.
- Reset mid-frame: lines return high immediately (asynchronously), the queue is flushed, and no partial frame resumes.

## Timing
- When `ps2_key[10]` toggles with the sequencer idle and the queue empty:
  - The toggle is sampled on edge k.
  - The queue write happens at k+1.
  - IDLE pops the entry at k+2.
  - LOAD drives `ps2_data`=0 (start bit) at k+3.
- Bit period is exactly 2·HALF cycles; frame length is 22·HALF cycles.
- Byte-to-byte spacing is 22·HALF + GAP cycles.
- `busy` rises at k+1 and falls on the cycle GAP ends with the queue empty.
- `overflow` is high for exactly one cycle per dropped event.

## Configuration
- `PS2_EVQ_EN` defined: the event queue is built as described above.
- `PS2_EVQ_EN` undefined: the queue is replaced by a single holding register.
  - An event is accepted only when the register is empty. The register is emptied by the IDLE pop.
  - Otherwise the event is dropped and `overflow` pulses.
  - All other timing is identical.

## Test plan
Bench settings: HALF=4, GAP=8.
1. Press, non-extended, code 0x1C. `ps2_data` is sampled at each `ps2_clk` fall.
   - Required: 0,0,0,1,1,1,0,0,0,0,1 (start, data LSB first, parity 0, stop).
   - Exactly one frame.
2. Release, extended, code 0x75.
   - Required: three frames E0, F0, 75 with parity bits 0, 1, 0.
   - Each frame start is 96 cycles after the previous frame start.
3. Timing: a toggle sampled at edge k.
   - Required: `ps2_data` falls at k+3 and `ps2_clk` first falls at k+7.
   - `busy` rises at k+1.
4. Overflow: 10 toggles on consecutive cycles with `PS2_EVQ_EN` defined.
   - Required: 9 events sent (1 popped immediately, 8 queued) and 1 `overflow` pulse.
   - With `PS2_EVQ_EN` undefined: 2 events sent and 8 pulses.
5. Reset at bit 5 of a frame.
   - Required: `ps2_clk` and `ps2_data` are 1 within the reset cycle and `busy`=0.
   - No frame follows release unless a new toggle occurs.
6. Reset release with `ps2_key[10]`=1.
   - Required: no frame is produced, confirming the shadow is loaded rather than compared.
